// File: rtl/lcd_timing_pkg.sv
// Default 800x480 panel timing and a helper that sums one axis' segment lengths.
package lcd_timing_pkg;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 30;
  localparam int DEF_H_BP     = 186;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 32;

  function automatic int axis_total(input int sync_w, input int bp, input int active, input int fp);
    return sync_w + bp + active + fp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_SYNC, DEF_H_BP, DEF_H_ACTIVE, DEF_H_FP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_SYNC, DEF_V_BP, DEF_V_ACTIVE, DEF_V_FP);

endpackage

// File: rtl/lcd_axis_counter.sv
// Wrapping 0..TOTAL-1 counter with enable; tc flags the last count of the period.
module lcd_axis_counter #(
  parameter int W     = 11,
  parameter int TOTAL = 1056
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;
  assign tc  = (cnt_reg == LAST);

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD sync/data-enable timing generator: free-running (hc,vc) raster with
// registered decodes of sync, active window, coordinates and start strobes.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int H_W      = 11,
  parameter int V_W      = 10,
  parameter int FRAME_W  = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  output logic               HD,
  output logic               VD,
  output logic               DEN,
  output logic [H_W-1:0]     X,
  output logic [V_W-1:0]     Y,
  output logic               LS,
  output logic               FS,
  output logic [FRAME_W-1:0] FCOUNT
);

  localparam int H_TOTAL = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        H_TOTAL >= (1 << H_W) || V_TOTAL >= (1 << V_W)) begin : g_bad_params
      $error("lcd_timing_gen: illegal timing parameters");
    end
  endgenerate

  localparam logic [H_W-1:0] H_SYNC_END  = H_W'(H_SYNC);
  localparam logic [H_W-1:0] H_ACT_START = H_W'(H_SYNC + H_BP);
  localparam logic [H_W-1:0] H_ACT_END   = H_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [V_W-1:0] V_SYNC_END  = V_W'(V_SYNC);
  localparam logic [V_W-1:0] V_ACT_START = V_W'(V_SYNC + V_BP);
  localparam logic [V_W-1:0] V_ACT_END   = V_W'(V_SYNC + V_BP + V_ACTIVE);

  logic [H_W-1:0] hc;
  logic [V_W-1:0] vc;
  logic           h_tc;
  logic           v_tc;

  lcd_axis_counter #(.W(H_W), .TOTAL(H_TOTAL)) u_hcnt (
    .clk  (CLK),
    .srst (RST),
    .en   (EN),
    .cnt  (hc),
    .tc   (h_tc)
  );

  lcd_axis_counter #(.W(V_W), .TOTAL(V_TOTAL)) u_vcnt (
    .clk  (CLK),
    .srst (RST),
    .en   (EN & h_tc),
    .cnt  (vc),
    .tc   (v_tc)
  );

  logic hd_next, vd_next, den_next, ls_next, fs_next;

  always_comb begin
    hd_next  = (hc < H_SYNC_END) ? HS_POL : ~HS_POL;
    vd_next  = (vc < V_SYNC_END) ? VS_POL : ~VS_POL;
    den_next = (hc >= H_ACT_START) && (hc < H_ACT_END) &&
               (vc >= V_ACT_START) && (vc < V_ACT_END);
    ls_next  = (hc == '0);
    fs_next  = ls_next && (vc == '0);
  end

  logic               hd_reg, vd_reg, den_reg, ls_reg, fs_reg;
  logic [H_W-1:0]     x_reg;
  logic [V_W-1:0]     y_reg;
  logic [FRAME_W-1:0] fcount_reg;
  // Set when a frame has wrapped, so only FS pulses that close a frame count it.
  logic               frame_done_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hd_reg         <= ~HS_POL;
      vd_reg         <= ~VS_POL;
      den_reg        <= 1'b0;
      ls_reg         <= 1'b0;
      fs_reg         <= 1'b0;
      x_reg          <= '0;
      y_reg          <= '0;
      fcount_reg     <= '0;
      frame_done_reg <= 1'b0;
    end else if (EN) begin
      hd_reg  <= hd_next;
      vd_reg  <= vd_next;
      den_reg <= den_next;
      ls_reg  <= ls_next;
      fs_reg  <= fs_next;
      if (den_next) begin
        x_reg <= hc - H_ACT_START;
        y_reg <= vc - V_ACT_START;
      end
      if (h_tc && v_tc) begin
        frame_done_reg <= 1'b1;
      end else if (fs_next) begin
        frame_done_reg <= 1'b0;
        if (frame_done_reg) fcount_reg <= fcount_reg + 1'b1;
      end
    end
  end

  assign HD     = hd_reg;
  assign VD     = vd_reg;
  assign DEN    = den_reg;
  assign LS     = ls_reg;
  assign FS     = fs_reg;
  assign X      = x_reg;
  assign Y      = y_reg;
  assign FCOUNT = fcount_reg;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench: vector table, directed corner sequences and random EN/RST
// against an arithmetic raster model (enabled-cycle index -> expected outputs).
module tb_lcd_timing_gen;

  typedef struct {
    int hs, hb, ha, hf, vs, vb, va, vf;
    bit hpol, vpol;
    int fw;
  } cfg_t;

  typedef struct {
    bit hd, vd, den, ls, fs;
    int x, y, fc;
  } exp_t;

  typedef struct {
    bit rst, en, hd, vd, den, ls, fs;
    int fc;
  } vec_t;

  localparam cfg_t CS = '{2, 2, 4, 2, 1, 1, 3, 1, 1'b0, 1'b0, 8};
  localparam cfg_t CP = '{2, 2, 4, 2, 1, 1, 3, 1, 1'b1, 1'b1, 8};
  localparam cfg_t CF = '{2, 2, 4, 2, 1, 1, 3, 1, 1'b0, 1'b0, 2};
  localparam cfg_t CD = '{30, 186, 800, 40, 3, 32, 480, 10, 1'b0, 1'b0, 8};

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst_s, en_s, rst_d, en_d;

  logic s_hd, s_vd, s_den, s_ls, s_fs;
  logic [3:0] s_x; logic [2:0] s_y; logic [7:0] s_fc;
  logic p_hd, p_vd, p_den, p_ls, p_fs;
  logic [3:0] p_x; logic [2:0] p_y; logic [7:0] p_fc;
  logic f_hd, f_vd, f_den, f_ls, f_fs;
  logic [3:0] f_x; logic [2:0] f_y; logic [1:0] f_fc;
  logic d_hd, d_vd, d_den, d_ls, d_fs;
  logic [10:0] d_x; logic [9:0] d_y; logic [7:0] d_fc;

  always #5 clk = ~clk;

  lcd_timing_gen #(.H_ACTIVE(4), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(3), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .H_W(4), .V_W(3),
                   .FRAME_W(8)) dut_s (
    .CLK(clk), .RST(rst_s), .EN(en_s), .HD(s_hd), .VD(s_vd), .DEN(s_den),
    .X(s_x), .Y(s_y), .LS(s_ls), .FS(s_fs), .FCOUNT(s_fc));

  lcd_timing_gen #(.H_ACTIVE(4), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(3), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .H_W(4), .V_W(3),
                   .FRAME_W(8)) dut_p (
    .CLK(clk), .RST(rst_s), .EN(en_s), .HD(p_hd), .VD(p_vd), .DEN(p_den),
    .X(p_x), .Y(p_y), .LS(p_ls), .FS(p_fs), .FCOUNT(p_fc));

  lcd_timing_gen #(.H_ACTIVE(4), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(3), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .H_W(4), .V_W(3),
                   .FRAME_W(2)) dut_f (
    .CLK(clk), .RST(rst_s), .EN(en_s), .HD(f_hd), .VD(f_vd), .DEN(f_den),
    .X(f_x), .Y(f_y), .LS(f_ls), .FS(f_fs), .FCOUNT(f_fc));

  lcd_timing_gen dut_d (
    .CLK(clk), .RST(rst_d), .EN(en_d), .HD(d_hd), .VD(d_vd), .DEN(d_den),
    .X(d_x), .Y(d_y), .LS(d_ls), .FS(d_fs), .FCOUNT(d_fc));

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic chk_inst(input string tag, input exp_t e, input bit hd, input bit vd,
                          input bit den, input bit ls, input bit fs, input int x,
                          input int y, input int fc);
    cmp({tag, "_hd"}, hd, e.hd);
    cmp({tag, "_vd"}, vd, e.vd);
    cmp({tag, "_den"}, den, e.den);
    cmp({tag, "_ls"}, ls, e.ls);
    cmp({tag, "_fs"}, fs, e.fs);
    cmp({tag, "_x"}, x, e.x);
    cmp({tag, "_y"}, y, e.y);
    cmp({tag, "_fc"}, fc, e.fc);
  endtask

  function automatic exp_t reset_exp(input cfg_t c);
    exp_t e;
    e.hd = !c.hpol; e.vd = !c.vpol; e.den = 0; e.ls = 0; e.fs = 0;
    e.x = 0; e.y = 0; e.fc = 0;
    return e;
  endfunction

  // n = number of enabled cycles since reset; position is plain div/mod of n.
  function automatic exp_t decode(input cfg_t c, input longint n, input exp_t prev);
    exp_t e;
    longint ht, vt, hc, vc;
    ht = c.hs + c.hb + c.ha + c.hf;
    vt = c.vs + c.vb + c.va + c.vf;
    hc = n % ht;
    vc = (n / ht) % vt;
    e = prev;
    e.hd  = (hc < c.hs) ? c.hpol : !c.hpol;
    e.vd  = (vc < c.vs) ? c.vpol : !c.vpol;
    e.den = (hc >= c.hs + c.hb) && (hc < c.hs + c.hb + c.ha) &&
            (vc >= c.vs + c.vb) && (vc < c.vs + c.vb + c.va);
    if (e.den) begin
      e.x = int'(hc - (c.hs + c.hb));
      e.y = int'(vc - (c.vs + c.vb));
    end
    e.ls = (hc == 0);
    e.fs = (hc == 0) && (vc == 0);
    e.fc = int'((n / (ht * vt)) % (longint'(1) << c.fw));
    return e;
  endfunction

  longint n_sm, n_d;
  exp_t es, ep, ef, ed;
  int d_cyc = 0, d_last_ls = -1, d_lines = 0, d_den_cnt = 0;

  // Continuous model checker for all four instances.
  initial begin
    bit r, e, rd;
    int vprev;
    forever begin
      @(posedge clk);
      r = rst_s; e = en_s; rd = rst_d;
      if (r) begin
        n_sm = 0; es = reset_exp(CS); ep = reset_exp(CP); ef = reset_exp(CF);
      end else if (e) begin
        es = decode(CS, n_sm, es); ep = decode(CP, n_sm, ep); ef = decode(CF, n_sm, ef);
        n_sm++;
      end
      if (rd) begin
        n_d = 0; ed = reset_exp(CD);
      end else begin
        ed = decode(CD, n_d, ed);
        n_d++;
      end
      #1;
      chk_inst("s", es, s_hd, s_vd, s_den, s_ls, s_fs, int'(s_x), int'(s_y), int'(s_fc));
      chk_inst("p", ep, p_hd, p_vd, p_den, p_ls, p_fs, int'(p_x), int'(p_y), int'(p_fc));
      chk_inst("f", ef, f_hd, f_vd, f_den, f_ls, f_fs, int'(f_x), int'(f_y), int'(f_fc));
      chk_inst("d", ed, d_hd, d_vd, d_den, d_ls, d_fs, int'(d_x), int'(d_y), int'(d_fc));
      if (!rd) begin
        if (d_ls) begin
          if (d_last_ls >= 0) cmp("d_ls_gap", d_cyc - d_last_ls, 1056);
          if (d_lines >= 1) begin
            vprev = (d_lines - 1) % 525;
            cmp("d_line_den", d_den_cnt, (vprev >= 35 && vprev < 515) ? 800 : 0);
          end
          d_last_ls = d_cyc;
          d_lines++;
          d_den_cnt = 0;
        end
        if (d_den) d_den_cnt++;
        d_cyc++;
      end
    end
  end

  vec_t tbl[15];
  int hd_cnt, den_cnt, fs_cnt, ls_cnt, fs_k0, fs_k1, cnt, guard;
  int fc_seq[$];
  bit found;

  initial begin
    rst_s = 1'b1; en_s = 1'b1; rst_d = 1'b1; en_d = 1'b1;
    //          rst en  hd vd den ls fs fc
    tbl[0]  = '{1, 1, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 1, 1, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 1, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 1, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 1, 1, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 1, 1, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 1, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 1, 1, 0, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 0, 1, 0, 1, 0, 0};
    tbl[13] = '{1, 0, 1, 1, 0, 0, 0, 0};
    tbl[14] = '{0, 1, 0, 0, 0, 1, 1, 0};

    @(negedge clk); rst_d = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); rst_s = tbl[i].rst; en_s = tbl[i].en;
      @(posedge clk); #1;
      cmp($sformatf("tbl%0d_hd", i), s_hd, tbl[i].hd);
      cmp($sformatf("tbl%0d_vd", i), s_vd, tbl[i].vd);
      cmp($sformatf("tbl%0d_den", i), s_den, tbl[i].den);
      cmp($sformatf("tbl%0d_ls", i), s_ls, tbl[i].ls);
      cmp($sformatf("tbl%0d_fs", i), s_fs, tbl[i].fs);
      cmp($sformatf("tbl%0d_fc", i), int'(s_fc), tbl[i].fc);
      cmp($sformatf("tbl%0d_x", i), int'(s_x), 0);
    end

    // Two full frames at EN=1 from reset: duty-cycle statistics.
    @(negedge clk); rst_s = 1'b1; en_s = 1'b1;
    @(negedge clk); rst_s = 1'b0;
    hd_cnt = 0; den_cnt = 0; fs_cnt = 0; ls_cnt = 0; fs_k0 = -1; fs_k1 = -1;
    for (int k = 0; k < 120; k++) begin
      @(posedge clk); #1;
      if (!s_hd) hd_cnt++;
      if (s_den) den_cnt++;
      if (s_ls) ls_cnt++;
      if (s_fs) begin
        fs_cnt++;
        if (fs_k0 < 0) fs_k0 = k; else fs_k1 = k;
      end
    end
    cmp("stat_hd_active", hd_cnt, 24);
    cmp("stat_den", den_cnt, 24);
    cmp("stat_ls", ls_cnt, 12);
    cmp("stat_fs", fs_cnt, 2);
    cmp("stat_fs_gap", fs_k1 - fs_k0, 60);

    // Freeze mid active line at X=1 for 7 cycles.
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk); #1;
      if (s_den && s_x == 4'd1) found = 1;
    end
    if (!found) begin
      checks++; failures++;
      $display("FAIL wait_x1 timed out, X=1 with DEN never seen");
    end
    @(negedge clk); en_s = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      cmp("freeze_x", int'(s_x), 1);
      cmp("freeze_den", s_den, 1);
    end
    @(negedge clk); en_s = 1'b1;
    @(posedge clk); #1;
    cmp("resume_x", int'(s_x), 2);
    cnt = s_den ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (s_ls) break;
      if (s_den) cnt++;
    end
    cmp("line_den_total", cnt + 2, 4);

    // Mid-frame reset with counters at hc=5, vc=2.
    found = (n_sm % 60 == 25);
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge clk); #1;
      if (n_sm % 60 == 25) found = 1;
    end
    if (!found) begin
      checks++; failures++;
      $display("FAIL wait_hc5_vc2 timed out");
    end
    cmp("pre_rst_fc_nonzero", (s_fc != 0) ? 1 : 0, 1);
    @(negedge clk); rst_s = 1'b1;
    @(posedge clk); #1;
    cmp("rst_hd", s_hd, 1);
    cmp("rst_vd", s_vd, 1);
    cmp("rst_den", s_den, 0);
    cmp("rst_ls", s_ls, 0);
    cmp("rst_fs", s_fs, 0);
    cmp("rst_fc", int'(s_fc), 0);
    cmp("rst_x", int'(s_x), 0);
    cmp("rst_y", int'(s_y), 0);
    @(negedge clk); rst_s = 1'b0;
    @(posedge clk); #1;
    cmp("post_rst_fs", s_fs, 1);
    cmp("post_rst_ls", s_ls, 1);
    cmp("post_rst_fc", int'(s_fc), 0);
    cmp("post_rst_hd", s_hd, 0);

    // FRAME_W=2 instance over 5 frames.
    if (f_fs) fc_seq.push_back(int'(f_fc));
    for (int k = 0; k < 400 && fc_seq.size() < 5; k++) begin
      @(posedge clk); #1;
      if (f_fs) fc_seq.push_back(int'(f_fc));
    end
    cmp("fc_seq_len", fc_seq.size(), 5);
    for (int i = 0; i < fc_seq.size() && i < 5; i++)
      cmp($sformatf("fc_seq%0d", i), fc_seq[i], i % 4);

    // Random EN with rare resets; the model checker covers every cycle.
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      en_s  = ($urandom_range(0, 3) != 0);
      rst_s = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk); rst_s = 1'b0; en_s = 1'b1;

    // Let the default-timing instance reach its first active lines.
    guard = 0;
    while (d_lines < 37 && guard < 45000) begin
      @(posedge clk); guard++;
    end
    if (d_lines < 37) begin
      checks++; failures++;
      $display("FAIL wait_default_lines timed out lines=%0d required=37", d_lines);
    end
    @(posedge clk); #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 Parameter H_FP, default 40, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 30, horizontal sync width in clocks.
REQ-004 Parameter H_BP, default 186, horizontal back porch in clocks (H_TOTAL = sum of the four = 1056).
REQ-005 Parameters V_ACTIVE 480, V_FP 10, V_SYNC 3, V_BP 32, vertical equivalents in lines (V_TOTAL = 525).
REQ-006 Parameters HS_POL and VS_POL, default 0, set the active sync level (0 = active-low, 1 = active-high).
REQ-007 Parameters H_W 11, V_W 10, FRAME_W 8, set the widths of X, Y and FCOUNT.
REQ-008 CLK  input  1  pixel clock; the only clock.
REQ-009 RST  input  1  reset, synchronous, active-high.
REQ-010 EN  input  1  advance enable; when low the whole block freezes.
REQ-011 HD  output  1  horizontal sync at the HS_POL level.
REQ-012 VD  output  1  vertical sync at the VS_POL level.
REQ-013 DEN  output  1  data enable; high only in the active region.
REQ-014 X  output  H_W  active column, 0..H_ACTIVE-1.
REQ-015 Y  output  V_W  active row, 0..V_ACTIVE-1.
REQ-016 LS  output  1  line-start strobe.
REQ-017 FS  output  1  frame-start strobe.
REQ-018 FCOUNT  output  FRAME_W  completed-frame count.

Function
REQ-019 Internal counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1) advance only on cycles where EN=1.
REQ-020 hc increments every enabled cycle; at H_TOTAL-1 it wraps to 0 and vc increments; at vc=V_TOTAL-1 with hc=H_TOTAL-1, vc wraps to 0.
REQ-021 Line segment order is fixed: sync [0,H_SYNC), back porch, active [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), front porch; lines use the same order.
REQ-022 All outputs are registered decodes of (hc,vc), updated only when EN=1, with a latency of exactly one enabled cycle after the counter value.
REQ-023 HD is active while hc<H_SYNC; VD is active while vc<V_SYNC, covering whole lines.
REQ-024 DEN=1 iff both hc and vc are inside their active windows.
REQ-025 When DEN=1: X = hc-(H_SYNC+H_BP) and Y = vc-(V_SYNC+V_BP). When DEN=0, X and Y hold their last values.
REQ-026 LS is high for one output cycle when hc=0; FS is high for one output cycle when hc=0 and vc=0, coincident with LS.
REQ-027 FCOUNT increments on the same cycle FS asserts, except for the first FS after reset, and wraps modulo 2^FRAME_W.
REQ-028 EN=0 holds the counters and all registered outputs, and strobes do not repeat; after EN returns high the sequence resumes from the held point.
REQ-029 Legal parameter values: every porch, sync and active value is at least 1, and H_TOTAL fits in H_W bits, V_TOTAL in V_W bits; an elaboration check fails otherwise.

Reset
REQ-030 RST=1 at a CLK edge sets hc=vc=0, HD/VD inactive, DEN=0, X=Y=0, LS=FS=0 and FCOUNT=0, overriding EN; this applies mid-frame as well.
REQ-031 The first enabled cycle after RST is released outputs the decode of hc=0, vc=0 (LS=FS=1, HD/VD active).

Structure
REQ-032 Package lcd_timing_pkg holds the default timing constants for the 800x480 panel and a function computing the totals.
REQ-033 One sub-module, lcd_axis_counter (wrapping counter with enable and terminal-count output), is instantiated twice: once for hc and once for vc.

Verification
REQ-034 Bench parameters H 2/2/4/2 (SYNC/BP/ACTIVE/FP) and V 1/1/3/1, EN=1: HD active for 2 of every 10 cycles, DEN 4 cycles per active line with X=0..3, Y=0..2, FS every 60 cycles.
REQ-035 Default parameters over 2 frames: exactly 1056 cycles between LS pulses, 554400 between FS pulses, 384000 DEN cycles per frame, FCOUNT=1 after the second FS.
REQ-036 EN low for 7 cycles mid-active line (bench parameters) -> all outputs frozen, X resumes at the next value, and the line still has exactly 4 DEN cycles.
REQ-037 RST pulsed at vc=2, hc=5 -> next cycle shows reset values; the following enabled cycle shows FS=LS=1 and FCOUNT=0.
REQ-038 HS_POL=1, VS_POL=1 -> HD/VD waveforms are the bit-inverse of the default case; DEN, X and Y are unchanged.
REQ-039 FRAME_W=2, run 5 frames -> FCOUNT sequence 0,1,2,3,0.
